// File: rtl/move_controller.sv
// Player movement sequencer: turns held direction keys into one-shot move codes for the
// collision detector, waits for it to settle, then latches the detector's proposed position.
module move_controller #(
  parameter logic [4:0] START_X       = 5'd1,
  parameter logic [4:0] START_Y       = 5'd2,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         REPEAT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] dir_keys,
  input  logic       respawn,
  input  logic [4:0] new_x_pos,
  input  logic [4:0] new_y_pos,
  output logic [2:0] move,
  output logic [4:0] cur_x,
  output logic [4:0] cur_y,
  output logic       moved,
  output logic       blocked,
  output logic       busy,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    COMMIT = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [23:0] REPEAT_LAST = 24'(REPEAT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  move_q, move_d;
  logic [4:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic        moved_q, moved_d, blocked_q, blocked_d, busy_q, busy_d;
  logic [3:0]  settle_q, settle_d;
  logic [23:0] repeat_q, repeat_d;

  function automatic logic [2:0] key_code(input logic [3:0] keys);
    if (keys[3])      key_code = 3'b100;
    else if (keys[2]) key_code = 3'b001;
    else if (keys[1]) key_code = 3'b010;
    else if (keys[0]) key_code = 3'b011;
    else              key_code = 3'b000;
  endfunction

  // Detector handshake: a non-zero move code is a request held steady from ISSUE through
  // COMMIT; the detector's answer is trusted only in COMMIT, and move returns to 000 before
  // any further request so the detector sees a fresh change every time.
  always_comb begin
    state_d   = state_q;
    move_d    = move_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    settle_d  = settle_q;
    repeat_d  = repeat_q;
    case (state_q)
      IDLE: begin
        move_d = 3'b000;
        if (dir_keys != 4'd0) begin
          state_d = ISSUE;
          move_d  = key_code(dir_keys);
        end
      end
      ISSUE: begin
        settle_d = SETTLE_LOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) state_d = COMMIT;
      end
      COMMIT: begin
        cur_x_d   = new_x_pos;
        cur_y_d   = new_y_pos;
        moved_d   = (new_x_pos != cur_x_q) || (new_y_pos != cur_y_q);
        blocked_d = !moved_d;
        move_d    = 3'b000;
        settle_d  = 4'd0;
        repeat_d  = 24'd0;
        state_d   = HOLD;
      end
      HOLD: begin
        move_d = 3'b000;
        if (dir_keys == 4'd0) begin
          state_d  = IDLE;
          repeat_d = 24'd0;
        end else if (repeat_q == REPEAT_LAST) begin
          state_d  = ISSUE;
          move_d   = key_code(dir_keys);
          repeat_d = 24'd0;
        end else begin
          repeat_d = repeat_q + 24'd1;
        end
      end
      default: begin
        state_d = IDLE;
        move_d  = 3'b000;
      end
    endcase
    // Respawn overrides everything, including a result arriving in COMMIT.
    if (respawn) begin
      state_d   = IDLE;
      move_d    = 3'b000;
      cur_x_d   = START_X;
      cur_y_d   = START_Y;
      moved_d   = 1'b0;
      blocked_d = 1'b0;
      settle_d  = 4'd0;
      repeat_d  = 24'd0;
    end
    busy_d = (state_d == ISSUE) || (state_d == SETTLE) || (state_d == COMMIT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      move_q    <= 3'b000;
      cur_x_q   <= START_X;
      cur_y_q   <= START_Y;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
      busy_q    <= 1'b0;
      settle_q  <= 4'd0;
      repeat_q  <= 24'd0;
    end else begin
      state_q   <= state_d;
      move_q    <= move_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
      busy_q    <= busy_d;
      settle_q  <= settle_d;
      repeat_q  <= repeat_d;
    end
  end

  assign move      = move_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign moved     = moved_q;
  assign blocked   = blocked_q;
  assign busy      = busy_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed key presses against a small collision-detector model,
// with committed positions checked by a scoreboard monitor on every moved/blocked pulse.
module tb_move_controller;

  logic       clk;
  logic       resetn;
  logic [3:0] dir_keys;
  logic       respawn;
  logic [4:0] new_x_pos, new_y_pos;
  logic [2:0] move;
  logic [4:0] cur_x, cur_y;
  logic       moved, blocked, busy;
  logic [2:0] fsm_state;
  logic       teleport;

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_q[$];

  move_controller #(
    .START_X(5'd1), .START_Y(5'd2), .SETTLE_CYCLES(2), .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk), .resetn(resetn), .dir_keys(dir_keys), .respawn(respawn),
    .new_x_pos(new_x_pos), .new_y_pos(new_y_pos), .move(move),
    .cur_x(cur_x), .cur_y(cur_y), .moved(moved), .blocked(blocked),
    .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Collision detector model: walls at x=0 and x=19, y wraps freely.
  logic [4:0] tx;
  always_comb begin
    new_x_pos = cur_x;
    new_y_pos = cur_y;
    tx        = 5'd0;
    if (teleport) begin
      new_x_pos = 5'd5;
      new_y_pos = 5'd7;
    end else begin
      case (move)
        3'b100: begin tx = cur_x + 5'd1; if (tx != 5'd19) new_x_pos = tx; end
        3'b010: begin tx = cur_x - 5'd1; if (tx != 5'd0)  new_x_pos = tx; end
        3'b001: new_y_pos = cur_y - 5'd1;
        3'b011: new_y_pos = cur_y + 5'd1;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn && (moved || blocked)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {moved, blocked}, 0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("commit_result", {20'd0, moved, blocked, cur_x, cur_y}, {20'd0, e});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (fsm_state == 3'd0 && !busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 1, 0);
  endtask

  task automatic press(input logic [3:0] keys, input logic [2:0] code,
                       input logic exp_m, input logic [4:0] ex, input logic [4:0] ey);
    exp_q.push_back({exp_m, ~exp_m, ex, ey});
    dir_keys = keys;
    tick();
    dir_keys = 4'd0;
    @(negedge clk);
    check("issue_code", move, code);
    check("issue_busy", busy, 1);
    wait_idle();
  endtask

  logic [2:0] exp_states [4] = '{3'd1, 3'd2, 3'd2, 3'd3};

  initial begin
    int issues, last;
    logic [2:0] prev_move;
    resetn = 1'b0; dir_keys = 4'd0; respawn = 1'b0; teleport = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", fsm_state, 0);
    check("rst_move", move, 0);
    check("rst_x", cur_x, 1);
    check("rst_y", cur_y, 2);
    check("rst_moved", moved, 0);
    check("rst_blocked", blocked, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1;
    @(negedge clk);

    // single right press: code held 4 cycles, then 000 in HOLD
    exp_q.push_back({1'b1, 1'b0, 5'd2, 5'd2});
    dir_keys = 4'b1000;
    tick();
    dir_keys = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("right_move", move, 3'b100);
      check("right_busy", busy, 1);
      check("right_state", fsm_state, exp_states[i]);
    end
    @(negedge clk);
    check("right_after_move", move, 0);
    check("right_after_busy", busy, 0);
    check("right_hold", fsm_state, 4);
    wait_idle();

    press(4'b0010, 3'b010, 1'b1, 5'd1, 5'd2);   // left (2,2)->(1,2)
    press(4'b0010, 3'b010, 1'b0, 5'd1, 5'd2);   // left into wall
    press(4'b0110, 3'b001, 1'b1, 5'd1, 5'd1);   // up+left: up wins

    // right held: 17 moves to x=18, then blocked by wall at 19
    for (int x = 2; x <= 18; x++) exp_q.push_back({1'b1, 1'b0, 5'(x), 5'd1});
    repeat (2) exp_q.push_back({1'b0, 1'b1, 5'd18, 5'd1});
    dir_keys = 4'b1000;
    issues = 0; last = 0; prev_move = 3'b000;
    for (int c = 0; c < 400 && issues < 19; c++) begin
      @(negedge clk);
      if (move != 3'b000 && prev_move == 3'b000) begin
        issues++;
        check("held_code", move, 3'b100);
        if (issues > 1) check("repeat_gap", c - last, 8);
        last = c;
      end
      prev_move = move;
    end
    dir_keys = 4'd0;
    check("held_issues", issues, 19);
    wait_idle();
    check("held_final_x", cur_x, 18);

    // respawn during SETTLE after reaching (5,7)
    teleport = 1'b1;
    press(4'b1000, 3'b100, 1'b1, 5'd5, 5'd7);
    teleport = 1'b0;
    dir_keys = 4'b0001;
    tick();
    dir_keys = 4'd0;
    tick();
    check("respawn_in_settle", fsm_state, 2);
    respawn = 1'b1;
    tick();
    respawn = 1'b0;
    @(negedge clk);
    check("respawn_x", cur_x, 1);
    check("respawn_y", cur_y, 2);
    check("respawn_state", fsm_state, 0);
    check("respawn_move", move, 0);
    check("respawn_busy", busy, 0);
    repeat (6) @(negedge clk);

    // respawn coincident with COMMIT discards the detector result
    dir_keys = 4'b1000;
    tick();
    dir_keys = 4'd0;
    repeat (3) tick();
    check("commit_state", fsm_state, 3);
    respawn = 1'b1;
    tick();
    respawn = 1'b0;
    @(negedge clk);
    check("commit_respawn_x", cur_x, 1);
    check("commit_respawn_pulse", {moved, blocked}, 0);
    check("commit_respawn_state", fsm_state, 0);
    repeat (6) @(negedge clk);

    // asynchronous reset mid-COMMIT
    press(4'b1000, 3'b100, 1'b1, 5'd2, 5'd2);
    dir_keys = 4'b1000;
    tick();
    dir_keys = 4'd0;
    repeat (3) tick();
    check("pre_reset_state", fsm_state, 3);
    #2 resetn = 1'b0;
    #1;
    check("async_state", fsm_state, 0);
    check("async_move", move, 0);
    check("async_busy", busy, 0);
    check("async_x", cur_x, 1);
    check("async_y", cur_y, 2);
    check("async_pulse", {moved, blocked}, 0);
    @(negedge clk);

    // first key is taken on the first edge after release
    resetn = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 5'd2, 5'd2});
    dir_keys = 4'b1000;
    tick();
    dir_keys = 4'd0;
    check("post_reset_state", fsm_state, 1);
    check("post_reset_move", move, 3'b100);
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 Parameter START_X, default 5'd1: x position loaded on reset and respawn.
REQ-002 Parameter START_Y, default 5'd2: y position loaded on reset and respawn.
REQ-003 Parameter SETTLE_CYCLES, default 2, range 1..15: cycles the move code is held before the detector result is sampled.
REQ-004 Parameter REPEAT_CYCLES, default 12_500_000, range 1..2^24-1: auto-repeat interval while a key stays held.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 resetn  in  1  reset, asynchronous assert, active-low.
REQ-007 dir_keys  in  4  active-high, already synchronous to clk; [3]=right, [2]=up, [1]=left, [0]=down.
REQ-008 respawn  in  1  synchronous request to return to start position.
REQ-009 new_x_pos  in  5  x position proposed by the collision detector.
REQ-010 new_y_pos  in  5  y position proposed by the collision detector.
REQ-011 move  out  3  move code to the detector: 100 right, 001 up, 010 left, 011 down, 000 none.
REQ-012 cur_x  out  5  registered current x, fed to the detector's current_x_pos.
REQ-013 cur_y  out  5  registered current y, fed to the detector's current_y_pos.
REQ-014 moved  out  1  one-cycle pulse: committed position differs from the previous position.
REQ-015 blocked  out  1  one-cycle pulse: committed position equals the previous position.
REQ-016 busy  out  1  high in ISSUE, SETTLE and COMMIT.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, SETTLE, COMMIT and HOLD; all outputs SHALL be registered.
REQ-018 Key priority SHALL be right > up > left > down; the highest-priority asserted key selects the code.
REQ-019 IDLE: move=000; if dir_keys!=0 in cycle N, the FSM SHALL be in ISSUE in cycle N+1 with move driving the selected code.
REQ-020 ISSUE: the FSM SHALL spend 1 cycle here, load the settle counter with SETTLE_CYCLES, then go to SETTLE.
REQ-021 SETTLE: the counter SHALL decrement each cycle; the FSM SHALL go to COMMIT after exactly SETTLE_CYCLES cycles in SETTLE.
REQ-022 COMMIT (1 cycle): new_x_pos and new_y_pos SHALL be sampled; cur_x and cur_y SHALL take the sampled values at the end of the cycle.
REQ-023 In the cycle after COMMIT, moved or blocked (exactly one) SHALL be high for one cycle, and the FSM SHALL be in HOLD.
REQ-024 The move code SHALL be constant from ISSUE through COMMIT; dir_keys changes during busy SHALL be ignored.
REQ-025 HOLD: move=000; the repeat counter SHALL clear on entry and increment each cycle.
REQ-026 HOLD exit when dir_keys==0: the FSM SHALL go to IDLE next cycle.
REQ-027 HOLD exit when the counter reaches REPEAT_CYCLES-1 with any key held: the FSM SHALL go to ISSUE using the currently prioritized key.
REQ-028 move SHALL be 000 for at least one cycle between any two issued codes, since the detector re-evaluates only on a change of move.
REQ-029 The controller SHALL NOT clamp or wrap positions: it latches detector values verbatim, and 5-bit wrap-around is the detector's concern.
REQ-030 respawn SHALL be effective in any state, including mid-move: next cycle cur_x=START_X, cur_y=START_Y, move=000, state=IDLE, counters cleared, and no moved or blocked pulse.
REQ-031 respawn coincident with COMMIT SHALL win: the detector result is discarded.

Reset
REQ-032 While resetn=0: state=IDLE, move=000, cur_x=START_X, cur_y=START_Y, moved=blocked=busy=0, both counters 0, asynchronously.
REQ-033 After resetn deasserts, the first key SHALL be sampled on the first rising edge with resetn=1.

Verification (SETTLE_CYCLES=2, REPEAT_CYCLES=4, start (1,2), detector model with walls at x=0 and x=19)
REQ-034 Right pressed one cycle at (1,2): move=100 for 4 cycles, cur=(2,2), one moved pulse, move=000 afterwards.
REQ-035 Left pressed at (1,2) with wall at x=0: detector returns (1,2); cur stays (1,2), one blocked pulse, no moved pulse.
REQ-036 Right held continuously: moves repeat every 4 busy cycles + 4 HOLD cycles, with move=000 between issues; x increments per issue until the wall, then blocked pulses.
REQ-037 Up+left pressed together: move=001 issued, and the left press is never issued.
REQ-038 respawn asserted during SETTLE after cur moved to (5,7): next cycle cur=(1,2), state IDLE, move=000, no pulse.
REQ-039 resetn pulsed low mid-COMMIT: outputs take reset values immediately, without waiting for a clock edge.
